// File: rtl/tdm_mux_4.sv
// 4-to-1 TDM transmitter: four one-deep lane slots serialised onto a registered
// stream, with a 2-bit lane tag per beat. Fixed or work-conserving round-robin.

module tdm_mux_4_slot #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d_in,
  input  logic             d_valid,
  input  logic             drain,
  output logic             ready,
  output logic [WIDTH-1:0] hold,
  output logic             full
);
  assign ready = !full;

  // drain is only asserted while full, so it can never collide with a capture
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full <= 1'b0;
      hold <= '0;
    end else if (d_valid && !full) begin
      hold <= d_in;
      full <= 1'b1;
    end else if (drain) begin
      full <= 1'b0;
    end
  end
endmodule

module tdm_mux_4 #(
  parameter int WIDTH      = 1,
  parameter int SKIP_EMPTY = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             d_en,
  input  logic [WIDTH-1:0] d_in_0,
  input  logic [WIDTH-1:0] d_in_1,
  input  logic [WIDTH-1:0] d_in_2,
  input  logic [WIDTH-1:0] d_in_3,
  input  logic             d_valid_0,
  input  logic             d_valid_1,
  input  logic             d_valid_2,
  input  logic             d_valid_3,
  output logic             d_ready_0,
  output logic             d_ready_1,
  output logic             d_ready_2,
  output logic             d_ready_3,
  output logic [WIDTH-1:0] d_out,
  output logic [1:0]       d_sel,
  output logic             d_out_valid,
  output logic             d_frame
);
  localparam int NUM_LANES = 4;

  logic [NUM_LANES-1:0][WIDTH-1:0] lane_in, hold;
  logic [NUM_LANES-1:0]            lane_vld, ready, full, drain;
  logic [1:0]                      ptr, pick, idx;
  logic                            found;

  assign lane_in  = {d_in_3, d_in_2, d_in_1, d_in_0};
  assign lane_vld = {d_valid_3, d_valid_2, d_valid_1, d_valid_0};
  assign {d_ready_3, d_ready_2, d_ready_1, d_ready_0} = ready;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      tdm_mux_4_slot #(.WIDTH(WIDTH)) u_slot (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_in   (lane_in[gi]),
        .d_valid(lane_vld[gi]),
        .drain  (drain[gi]),
        .ready  (ready[gi]),
        .hold   (hold[gi]),
        .full   (full[gi])
      );
      assign drain[gi] = d_en && found && (pick == 2'(gi));
    end
  endgenerate

  // Fixed mode always visits ptr; work-conserving mode takes the first full slot from ptr on
  always_comb begin
    pick  = ptr;
    found = full[ptr];
    idx   = ptr;
    if (SKIP_EMPTY != 0) begin
      found = 1'b0;
      for (int j = 0; j < NUM_LANES; j++) begin
        idx = ptr + 2'(j);
        if (!found && full[idx]) begin
          pick  = idx;
          found = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr         <= 2'd0;
      d_out       <= '0;
      d_sel       <= 2'd0;
      d_out_valid <= 1'b0;
      d_frame     <= 1'b0;
    end else if (!d_en) begin
      d_out_valid <= 1'b0;
      d_frame     <= 1'b0;
    end else if (SKIP_EMPTY == 0) begin
      // empty slots still burn their time slot, so the frame marker stays periodic
      d_sel       <= ptr;
      d_out       <= full[ptr] ? hold[ptr] : '0;
      d_out_valid <= full[ptr];
      d_frame     <= (ptr == 2'd0);
      ptr         <= ptr + 2'd1;
    end else if (found) begin
      d_sel       <= pick;
      d_out       <= hold[pick];
      d_out_valid <= 1'b1;
      d_frame     <= (pick == 2'd0);
      ptr         <= pick + 2'd1;
    end else begin
      d_out_valid <= 1'b0;
      d_frame     <= 1'b0;
    end
  end
endmodule
